// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared constants for the two-requester APB master: FSM state
//               encoding and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default bus widths used by apb_arb_master
    localparam int c_ADDR_W_DEF = 8;
    localparam int c_DATA_W_DEF = 32;

    // Master FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_IDLE   = 2'b00;
    localparam state_t c_SETUP  = 2'b01;
    localparam state_t c_ACCESS = 2'b10;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arb2
// Description : Combinational two-input round-robin grant. A lone requester
//               always wins; on a tie the requester not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arb2
    import apb_pkg::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_gnt_valid,
    output logic o_gnt_idx
);

    // Pick a winner: tie goes to the requester other than the last one granted
    always_comb begin
        o_gnt_valid = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_gnt_idx = ~i_last_grant;
        end else begin
            o_gnt_idx = i_valid1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_master
// Description : Two-requester APB master. Arbitrates round-robin in IDLE and
//               runs the granted command through SETUP/ACCESS, returning done,
//               read data and error to the granted requester.
//               Optional macro APB_MASTER_TIMEOUT_EN adds an ACCESS timeout
//               that aborts the transfer after TIMEOUT cycles with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    state_t              r_state;
    logic                r_last_grant;
    logic                r_gnt;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic                r_psel;
    logic                r_penable;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_done0;
    logic                r_done1;
    logic                r_err0;
    logic                r_err1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic                w_cmd_write;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic [DATA_W-1:0]   w_cmd_wdata;
    logic                w_abort;

    // A TIMEOUT below 2 is not a meaningful configuration; nothing is built for it
    if (TIMEOUT < 2) begin : g_timeout_range
    end

    apb_rr_arb2 u_arb (
        .i_valid0     (r0_valid),
        .i_valid1     (r1_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx)
    );

    // Command presented by the arbitration winner
    always_comb begin
        w_cmd_write = w_gnt_idx ? r1_write : r0_write;
        w_cmd_addr  = w_gnt_idx ? r1_addr  : r0_addr;
        w_cmd_wdata = w_gnt_idx ? r1_wdata : r0_wdata;
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Count stalled ACCESS cycles; cleared while in SETUP so each ACCESS starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_SETUP) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_ACCESS && !pready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Still stalled on the TIMEOUT-th ACCESS cycle: give up at this edge
    assign w_abort = (r_state == c_ACCESS) && !pready && (r_tmo_cnt == c_TMO_LAST);
`else
    assign w_abort = 1'b0;
`endif

    // Master FSM, APB bus registers and per-requester response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwdata     <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_gnt_valid) begin
                        r_paddr      <= w_cmd_addr;
                        r_pwrite     <= w_cmd_write;
                        r_pwdata     <= w_cmd_wdata;
                        r_last_grant <= w_gnt_idx;
                        r_gnt        <= w_gnt_idx;
                        r_ack0       <= ~w_gnt_idx;
                        r_ack1       <= w_gnt_idx;
                        r_psel       <= 1'b1;
                        r_state      <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= c_IDLE;
                        if (r_gnt) begin
                            r_done1 <= 1'b1;
                            if (!r_pwrite) r_rdata1 <= prdata;
                        end else begin
                            r_done0 <= 1'b1;
                            if (!r_pwrite) r_rdata0 <= prdata;
                        end
                    end else if (w_abort) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= c_IDLE;
                        if (r_gnt) begin
                            r_done1  <= 1'b1;
                            r_err1   <= 1'b1;
                            r_rdata1 <= '0;
                        end else begin
                            r_done0  <= 1'b1;
                            r_err0   <= 1'b1;
                            r_rdata0 <= '0;
                        end
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign paddr    = r_paddr;
    assign pwrite   = r_pwrite;
    assign psel     = r_psel;
    assign penable  = r_penable;
    assign pwdata   = r_pwdata;
    assign r0_ack   = r_ack0;
    assign r1_ack   = r_ack1;
    assign r0_done  = r_done0;
    assign r1_done  = r_done1;
    assign r0_err   = r_err0;
    assign r1_err   = r_err1;
    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_arb_master
// Description : Self-checking bench for apb_arb_master with a transfer-level
//               reference model and directed scenarios. Honours the optional
//               macro APB_MASTER_TIMEOUT_EN (TIMEOUT fixed at 4 here).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_arb_master;

    localparam int c_TIMEOUT = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_write, r1_valid, r1_write;
    logic [7:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [7:0]  paddr;
    logic        pwrite, psel, penable, pready;
    logic [31:0] pwdata, prdata;

    int n_checks = 0;
    int n_errors = 0;

    apb_arb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- slave: pready after s_ws wait states ----------------
    int          s_ws = 0;
    logic [31:0] s_rdata = '0;
    int          s_acc = 0;
    always @(negedge clk) begin
        if (psel && penable) begin
            s_acc++;
            pready = (s_acc > s_ws);
            prdata = s_rdata;
        end else begin
            s_acc  = 0;
            pready = 1'b0;
            prdata = 32'h0;
        end
    end

    // ---------------- reference model ----------------
    // m_pos: 0 = no transfer, 1 = setup cycle, k>=2 = (k-1)-th access cycle
    int          m_pos = 0;
    bit          m_last = 1'b1;
    int          m_gnt = 0;
    logic [7:0]  m_paddr = '0;
    bit          m_pwrite = 1'b0;
    logic [31:0] m_pwdata = '0;
    bit          m_ack [2];
    bit          m_done [2];
    bit          m_err [2];
    logic [31:0] m_rdata [2];
    bit          started = 1'b0;

    always @(posedge clk) begin
        int who;
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
        if (rst) begin
            m_pos = 0; m_last = 1'b1; m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_pos == 0) begin
            if (r0_valid || r1_valid) begin
                who = (r0_valid && r1_valid) ? (m_last ? 0 : 1) : (r1_valid ? 1 : 0);
                m_paddr  = who ? r1_addr  : r0_addr;
                m_pwrite = who ? r1_write : r0_write;
                m_pwdata = who ? r1_wdata : r0_wdata;
                m_last   = (who == 1);
                m_gnt    = who;
                m_ack[who] = 1;
                m_pos    = 1;
            end
        end else if (m_pos == 1) begin
            m_pos = 2;
        end else begin
            if (pready) begin
                m_done[m_gnt] = 1;
                if (!m_pwrite) m_rdata[m_gnt] = prdata;
                m_pos = 0;
            end else if (c_TO_EN && (m_pos - 1) == c_TIMEOUT) begin
                m_done[m_gnt] = 1;
                m_err[m_gnt]  = 1;
                m_rdata[m_gnt] = '0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        started = 1'b1;
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("psel",     psel,     (m_pos >= 1));
            chk("penable",  penable,  (m_pos >= 2));
            chk("paddr",    paddr,    m_paddr);
            chk("pwrite",   pwrite,   m_pwrite);
            chk("pwdata",   pwdata,   m_pwdata);
            chk("r0_ack",   r0_ack,   m_ack[0]);
            chk("r1_ack",   r1_ack,   m_ack[1]);
            chk("r0_done",  r0_done,  m_done[0]);
            chk("r1_done",  r1_done,  m_done[1]);
            chk("r0_err",   r0_err,   m_err[0]);
            chk("r1_err",   r1_err,   m_err[1]);
            chk("r0_rdata", r0_rdata, m_rdata[0]);
            chk("r1_rdata", r1_rdata, m_rdata[1]);
        end
    end

    // Issue one command, wait (bounded) for ack and done; report ACCESS length
    task automatic run_cmd(input int req, input bit wr, input logic [7:0] a,
                           input logic [31:0] d, input int waits, input logic [31:0] rd,
                           output int acc, output bit got_err);
        bit got;
        s_ws = waits; s_rdata = rd;
        if (req == 0) begin r0_valid = 1; r0_write = wr; r0_addr = a; r0_wdata = d; end
        else          begin r1_valid = 1; r1_write = wr; r1_addr = a; r1_wdata = d; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (req == 0) ? r0_ack : r1_ack;
        end
        chk("ack_seen", got, 1'b1);
        if (req == 0) r0_valid = 0; else r1_valid = 0;
        got = 0; acc = 0; got_err = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (psel && penable) acc++;
            got = (req == 0) ? r0_done : r1_done;
            if (got) got_err = (req == 0) ? r0_err : r1_err;
        end
        chk("done_seen", got, 1'b1);
    endtask

    int acc;
    bit er;
    int ack_who [$];
    int ack_cyc [$];
    int extra;
    bit got;

    initial begin
        rst = 1; r0_valid = 0; r1_valid = 0; r0_write = 0; r1_write = 0;
        r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0;
        repeat (5) tick();
        chk("rst_psel", psel, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_r0_rdata", r0_rdata, 0);

        // r0 write 64 / DEADBEEF, zero wait states: exact latency
        rst = 0; s_ws = 0;
        r0_valid = 1; r0_write = 1; r0_addr = 8'd64; r0_wdata = 32'hDEADBEEF;
        tick();
        chk("t1_setup_psel", psel, 1); chk("t1_setup_penable", penable, 0);
        chk("t1_ack", r0_ack, 1);
        r0_valid = 0;
        tick();
        chk("t1_acc_penable", penable, 1); chk("t1_paddr", paddr, 64);
        chk("t1_pwrite", pwrite, 1); chk("t1_pwdata", pwdata, 32'hDEADBEEF);
        tick();
        chk("t1_done", r0_done, 1); chk("t1_err", r0_err, 0); chk("t1_idle_psel", psel, 0);

        // r1 read addr 16 with 2 wait states
        run_cmd(1, 0, 8'd16, 0, 2, 32'h12345678, acc, er);
        chk("t2_access_len", acc, 3);
        extra = 0;
        repeat (3) begin tick(); if (r1_done) extra++; end
        chk("t2_single_done", extra, 0);
        chk("t2_rdata_held", r1_rdata, 32'h12345678);

        // r0 read, then a stalled r0 read for the timeout behaviour
        run_cmd(0, 0, 8'h30, 0, 0, 32'hCAFEF00D, acc, er);
        chk("t3_rdata", r0_rdata, 32'hCAFEF00D);
        run_cmd(0, 0, 8'h20, 0, 6, 32'h0BADF00D, acc, er);
`ifdef APB_MASTER_TIMEOUT_EN
        chk("to_access_len", acc, 4); chk("to_err", er, 1); chk("to_rdata", r0_rdata, 0);
`else
        chk("nto_access_len", acc, 7); chk("nto_err", er, 0);
        chk("nto_rdata", r0_rdata, 32'h0BADF00D);
`endif

        // write with 3 wait states: bus fields held (checked by model every cycle)
        run_cmd(1, 1, 8'h55, 32'h0F0F1234, 3, 32'hFFFFFFFF, acc, er);
        chk("t5_access_len", acc, 4);
        chk("t5_rdata_unchanged", r1_rdata, 32'h12345678);

        // reset in the middle of a stalled r0 access
        s_ws = 1000;
        r0_valid = 1; r0_write = 0; r0_addr = 8'h40;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin tick(); got = r0_ack; end
        chk("t6_ack", got, 1);
        r0_valid = 0;
        tick(); tick();
        chk("t6_in_access", penable, 1);
        rst = 1;
        tick();
        chk("t6_rst_psel", psel, 0); chk("t6_rst_penable", penable, 0);
        chk("t6_no_done", r0_done, 0);
        rst = 0; s_ws = 0;
        r0_valid = 1; r1_valid = 1; r0_addr = 8'h41; r1_addr = 8'h42; r1_write = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin tick(); got = r0_ack | r1_ack; end
        chk("t6_r0_first", r0_ack, 1); chk("t6_r1_not_first", r1_ack, 0);
        r0_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = r1_ack; end
        chk("t6_r1_later", got, 1);
        r1_valid = 0;
        repeat (4) tick();

        // both valid continuously from reset: alternating grants, 3 cycles apart
        rst = 1;
        r0_valid = 1; r0_write = 1; r0_addr = 8'h01; r0_wdata = 32'h11111111;
        r1_valid = 1; r1_write = 0; r1_addr = 8'h02; s_rdata = 32'h22222222;
        tick(); tick();
        rst = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (r0_ack) begin ack_who.push_back(0); ack_cyc.push_back(c); end
            if (r1_ack) begin ack_who.push_back(1); ack_cyc.push_back(c); end
        end
        r0_valid = 0; r1_valid = 0;
        repeat (6) tick();
        chk("rr_ack_count", ack_who.size(), 5);
        if (ack_who.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_order", ack_who[k], k % 2);
                chk("rr_cycle", ack_cyc[k], 1 + 3 * k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
Two-requester APB master that arbitrates command requests round-robin and sequences each granted command through the APB IDLE/SETUP/ACCESS protocol. It sits between on-chip command sources (e.g. CPU bridge, DMA) and the APB slave register block. It returns read data and completion status to the requester that was granted.

Parameters:
ADDR_W, 8, APB address width (paddr)
DATA_W, 32, APB data width (pwdata/prdata and requester data)
TIMEOUT, 16, maximum ACCESS cycles before abort (>=2; used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
r0_valid / r1_valid  in  1  command request; hold command stable until ack
r0_write / r1_write  in  1  1=write, 0=read
r0_addr / r1_addr  in  ADDR_W  command address
r0_wdata / r1_wdata  in  DATA_W  write data
r0_ack / r1_ack  out  1  one-cycle pulse: command accepted
r0_done / r1_done  out  1  one-cycle pulse: transfer complete
r0_rdata / r1_rdata  out  DATA_W  read data, valid with done, held until that requester's next done
r0_err / r1_err  out  1  valid with done; 1=timed-out transfer
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_W  APB write data
pready  in  1  APB slave ready
prdata  in  DATA_W  APB read data

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: state=IDLE, psel=penable=pwrite=0, paddr=0, pwdata=0, all ack/done/err=0, all rdata=0, last_grant=1 (so r0 wins the first tie).
- Reset mid-transfer: bus is released at the next edge and no done is issued. The requester must re-issue its command.
- FSM IDLE: arbitration is sampled only here. With no valid, stay in IDLE with psel=0.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester other than last_grant.
  - On grant: latch addr/write/wdata onto paddr/pwrite/pwdata, update last_grant, go to SETUP, and pulse the granted ack in the SETUP cycle.
- FSM SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- FSM ACCESS: psel=1, penable=1. pready is sampled at each rising edge.
  - If pready=1: capture prdata into the granted rdata (reads only; on writes rdata is unchanged), pulse the granted done with err=0, drop psel/penable, go to IDLE.
  - If pready=0: stay in ACCESS with paddr/pwrite/pwdata held stable.
- Requester rule: after seeing ack, the requester deasserts valid or presents a new command by the next edge. The block does not re-arbitrate until it returns to IDLE.
- Latency:
  - valid sampled at edge N -> SETUP in cycle N+1 -> ACCESS in cycle N+2.
  - With zero wait states, done is high in cycle N+3 (IDLE).
  - Minimum transfer period is 3 cycles. One IDLE cycle always separates transfers.
- paddr/pwdata/pwrite keep their last values in IDLE; only psel/penable return to 0.

Optional Feature:
Macro APB_MASTER_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT+1) clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - If pready is still 0 on the TIMEOUT-th ACCESS cycle, abort: psel/penable drop, go to IDLE, granted done=1 with err=1 and rdata=0.
  - ACCESS therefore never exceeds TIMEOUT cycles.
- Undefined: no counter; ACCESS waits indefinitely for pready; err outputs are tied 0.

Decomposition:
- Package apb_pkg holds:
  - FSM state typedef: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Default ADDR_W/DATA_W constants.
- One sub-module, apb_rr_arb2: a combinational two-input round-robin grant from valids plus a last_grant register input. The FSM and datapath stay in apb_arb_master.

Test Plan:
- Reset 5 cycles, then r0 write addr 64 data 0xDEADBEEF, slave pready=1 -> SETUP at +1, ACCESS at +2 with paddr=64/pwrite=1/pwdata=0xDEADBEEF, r0_done at +3 with err=0.
- r1 read addr 16, slave returns prdata=0x12345678 after 2 wait states -> ACCESS lasts 3 cycles, r1_done once, r1_rdata=0x12345678 held afterwards.
- r0 and r1 both valid continuously from reset -> grants r0,r1,r0,r1. Bus shows four transfers each 3 cycles apart plus IDLE. Each ack fires exactly once per command.
- rst asserted during an ACCESS with pready=0 -> next cycle psel=penable=0, no done pulse; the following request is arbitrated normally with r0 priority.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT=4, pready held 0 -> ACCESS 4 cycles, then done=1/err=1/rdata=0. Without the macro, psel stays high until pready rises.
- Write with pready=0 for 3 cycles -> paddr/pwdata/pwrite are stable for the entire SETUP+ACCESS window.
